// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// sdram_arb_pkg
// Shared state encoding and constants for the two-port SDRAM arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int MIN_RETRY = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2
// Combinational 2-way arbiter: round-robin on last_grant or fixed port-0 priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // Contention: port 0 wins unless round-robin says port 0 went last.
        if (req == 2'b11) begin
            gnt = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// sdram_arbiter
// Shares one SDRAM controller between two requesters, re-issuing refresh-lost commands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 16,
    parameter int RETRY_CYCLES = 4,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic [ADDR_WIDTH-1:0] ctl_wr_addr,
    output logic [DATA_WIDTH-1:0] ctl_wr_data,
    output logic                  ctl_wr_en,
    output logic [ADDR_WIDTH-1:0] ctl_rd_addr,
    output logic                  ctl_rd_en,
    input  logic [DATA_WIDTH-1:0] ctl_rd_data,
    input  logic                  ctl_rd_rdy,
    input  logic                  ctl_busy
);

    // Busy appears 2 clk after an accepted enable, so the window can never be shorter than that.
    localparam int c_retry_load = (RETRY_CYCLES < MIN_RETRY) ? MIN_RETRY : RETRY_CYCLES;
    localparam int c_cnt_w      = $clog2(c_retry_load + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_retry_load);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  r_last_grant;
    logic                  r_gnt_port;
    logic                  r_op_we;
    logic [ADDR_WIDTH-1:0] r_op_addr;
    logic [DATA_WIDTH-1:0] r_op_wdata;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_sel;
    logic                  w_grant;
    logic                  w_rd_capture;
    logic [NUM_PORTS-1:0]  w_ack;

    assign w_req   = {p1_req, p0_req};
    assign w_sel   = w_gnt[1];
    assign w_grant = (r_state == IDLE) && (|w_req);

    rr_arbiter2 u_rr_arbiter2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ctl_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt == '0) begin
                    // Controller never went busy: the command was swallowed by a refresh.
                    w_state_nxt = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (r_op_we ? !ctl_busy : ctl_rd_rdy) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt_port   <= 1'b0;
            r_op_we      <= 1'b0;
            r_op_addr    <= '0;
            r_op_wdata   <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_sel;
            r_gnt_port   <= w_sel;
            r_op_we      <= w_sel ? p1_we    : p0_we;
            r_op_addr    <= w_sel ? p1_addr  : p0_addr;
            r_op_wdata   <= w_sel ? p1_wdata : p0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= c_cnt_load;
        end else if ((r_state == WAIT_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_rd_capture = (r_state == WAIT_DONE) && !r_op_we && ctl_rd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rdata[p] <= '0;
            end
        end else if (w_rd_capture) begin
            r_rdata[r_gnt_port] <= ctl_rd_data;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_ack[p] = (r_state == ACK) && (r_gnt_port == 1'(p));
    end

    assign p0_ack   = w_ack[0];
    assign p1_ack   = w_ack[1];
    assign p0_rdata = r_rdata[0];
    assign p1_rdata = r_rdata[1];

    assign ctl_wr_en   = (r_state == ISSUE) &&  r_op_we;
    assign ctl_rd_en   = (r_state == ISSUE) && !r_op_we;
    assign ctl_wr_addr = r_op_addr;
    assign ctl_rd_addr = r_op_addr;
    assign ctl_wr_data = r_op_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// tb_sdram_arbiter
// Directed bench: instance 0 round-robin, instance 1 fixed priority, each with a controller model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] p0_req, p0_we, p1_req, p1_we, p0_ack, p1_ack;
    logic [NI-1:0] wr_en, rd_en, rd_rdy, busy, spur;
    logic [AW-1:0] p0_addr [NI];
    logic [AW-1:0] p1_addr [NI];
    logic [AW-1:0] wr_addr [NI];
    logic [AW-1:0] rd_addr [NI];
    logic [DW-1:0] p0_wdata [NI];
    logic [DW-1:0] p1_wdata [NI];
    logic [DW-1:0] p0_rdata [NI];
    logic [DW-1:0] p1_rdata [NI];
    logic [DW-1:0] wr_data [NI];
    logic [DW-1:0] rd_data [NI];

    int cyc = 0;
    int refresh_end [NI];
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        sdram_arbiter #(
            .ADDR_WIDTH   (AW),
            .DATA_WIDTH   (DW),
            .RETRY_CYCLES (4),
            .FIXED_PRIO   (g)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .p0_req      (p0_req[g]),
            .p0_we       (p0_we[g]),
            .p0_addr     (p0_addr[g]),
            .p0_wdata    (p0_wdata[g]),
            .p0_ack      (p0_ack[g]),
            .p0_rdata    (p0_rdata[g]),
            .p1_req      (p1_req[g]),
            .p1_we       (p1_we[g]),
            .p1_addr     (p1_addr[g]),
            .p1_wdata    (p1_wdata[g]),
            .p1_ack      (p1_ack[g]),
            .p1_rdata    (p1_rdata[g]),
            .ctl_wr_addr (wr_addr[g]),
            .ctl_wr_data (wr_data[g]),
            .ctl_wr_en   (wr_en[g]),
            .ctl_rd_addr (rd_addr[g]),
            .ctl_rd_en   (rd_en[g]),
            .ctl_rd_data (rd_data[g]),
            .ctl_rd_rdy  (rd_rdy[g]),
            .ctl_busy    (busy[g])
        );

        // Controller model: phase 1 the cycle after acceptance, busy from phase 2,
        // write busy ends after phase 5, read data ready in phase 7.
        logic [DW-1:0] mem [256];
        logic [2:0]    ph;
        logic          op_rd;
        logic [DW-1:0] rval;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ph    <= 3'd0;
                op_rd <= 1'b0;
                rval  <= '0;
            end else if (ph != 3'd0) begin
                ph <= ph + 3'd1;
            end else if ((wr_en[g] || rd_en[g]) && (cyc >= refresh_end[g])) begin
                ph    <= 3'd1;
                op_rd <= rd_en[g];
                if (wr_en[g]) mem[wr_addr[g][7:0]] <= wr_data[g];
                else          rval <= mem[rd_addr[g][7:0]];
            end
        end

        assign busy[g]    = (ph >= 3'd2) && (ph <= (op_rd ? 3'd6 : 3'd5));
        assign rd_rdy[g]  = (op_rd && (ph == 3'd7)) || spur[g];
        assign rd_data[g] = (op_rd && (ph == 3'd7)) ? rval : 16'hDEAD;

        int n_wr = 0;
        int n_rd = 0;
        int n_ack1 = 0;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;

        always @(posedge clk) begin
            if (wr_en[g]) begin
                n_wr <= n_wr + 1;
                wa   <= wr_addr[g];
                wd   <= wr_data[g];
            end
            if (rd_en[g]) n_rd <= n_rd + 1;
            if (p1_ack[g]) n_ack1 <= n_ack1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges from request to ack, or -1 on timeout.
    task automatic wait_ack(input int k, input int port, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((port == 0) ? p0_ack[k] : p1_ack[k]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic both_held(input int k, input logic [3:0] exp_ports, input string tag);
        int got;
        p0_req[k] = 1'b1;
        p1_req[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = -1;
            for (int n = 0; n < 40; n++) begin
                tick();
                if (p0_ack[k]) begin got = 0; break; end
                if (p1_ack[k]) begin got = 1; break; end
            end
            check(tag, got, 32'(exp_ports[i]));
            if (got == 1) p1_req[k] = 1'b0;
            else          p0_req[k] = 1'b0;
            if (i == 3) begin
                p0_req[k] = 1'b0;
                p1_req[k] = 1'b0;
            end else begin
                tick();
                if (got == 1) p1_req[k] = 1'b1;
                else          p0_req[k] = 1'b1;
            end
        end
    endtask

    int lat;
    int base_wr, base_rd, base_ack1;

    initial begin
        p0_req = '0; p0_we = '0; p1_req = '0; p1_we = '0; spur = '0;
        for (int k = 0; k < NI; k++) begin
            p0_addr[k] = '0; p1_addr[k] = '0; p0_wdata[k] = '0; p1_wdata[k] = '0;
            refresh_end[k] = 0;
        end

        #1;
        check("rst_strobes", {28'd0, wr_en[0], rd_en[0], p0_ack[0], p1_ack[0]}, 32'd0);
        check("rst_addr", 32'(wr_addr[0]), 32'd0);
        check("rst_rdata", {p0_rdata[0], p1_rdata[0]}, 32'd0);

        #20 rst_n = 1'b1;
        tick(); tick();

        // Round-robin alternation with both ports held from reset.
        p0_we[0] = 1'b1; p0_addr[0] = 25'h10; p0_wdata[0] = 16'h1111;
        p1_we[0] = 1'b1; p1_addr[0] = 25'h20; p1_wdata[0] = 16'h2222;
        both_held(0, 4'b1010, "rr_order");
        tick(); tick();

        // Single write: one enable pulse carrying the latched address/data.
        base_wr = g_inst[0].n_wr;
        p0_we[0] = 1'b1; p0_addr[0] = 25'h0001234; p0_wdata[0] = 16'hBEEF;
        p0_req[0] = 1'b1;
        wait_ack(0, 0, lat);
        p0_req[0] = 1'b0;
        check("wr_latency", lat, 32'd8);
        check("wr_pulses", g_inst[0].n_wr - base_wr, 32'd1);
        check("wr_addr", 32'(g_inst[0].wa), 32'h0001234);
        check("wr_data", 32'(g_inst[0].wd), 32'h0000BEEF);
        tick(); tick();

        // Readback on port 0; port 1 must stay silent.
        base_ack1 = g_inst[0].n_ack1;
        p0_we[0] = 1'b0; p0_addr[0] = 25'h0001234;
        p0_req[0] = 1'b1;
        wait_ack(0, 0, lat);
        check("rd_latency", lat, 32'd9);
        check("rd_data", 32'(p0_rdata[0]), 32'h0000BEEF);
        p0_req[0] = 1'b0;
        tick(); tick();
        check("rd_p1_quiet", g_inst[0].n_ack1 - base_ack1, 32'd0);

        // Refresh collision: enables ignored for 12 clk, issued at 1, 7, 13; accepted at 13.
        base_rd = g_inst[0].n_rd;
        base_ack1 = g_inst[0].n_ack1;
        p1_we[0] = 1'b0; p1_addr[0] = 25'h20;
        refresh_end[0] = cyc + 12;
        p1_req[0] = 1'b1;
        wait_ack(0, 1, lat);
        p1_req[0] = 1'b0;
        check("rfsh_latency", lat, 32'd21);
        check("rfsh_data", 32'(p1_rdata[0]), 32'h00002222);
        tick(); tick(); tick();
        check("rfsh_issues", g_inst[0].n_rd - base_rd, 32'd3);
        check("rfsh_one_ack", g_inst[0].n_ack1 - base_ack1, 32'd1);
        check("rfsh_p0_hold", 32'(p0_rdata[0]), 32'h0000BEEF);

        // Spurious rd_rdy inside a write's WAIT_DONE must not complete it early.
        p0_we[0] = 1'b1; p0_addr[0] = 25'h55; p0_wdata[0] = 16'hA5A5;
        p0_req[0] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            spur[0] = (n == 4) || (n == 5);
            if (p0_ack[0]) begin
                lat = n;
                break;
            end
        end
        spur[0] = 1'b0;
        p0_req[0] = 1'b0;
        check("spur_latency", lat, 32'd8);
        check("spur_rdata", 32'(p0_rdata[0]), 32'h0000BEEF);
        tick(); tick();

        // Asynchronous reset while a read sits in WAIT_DONE.
        p0_we[0] = 1'b0; p0_addr[0] = 25'h0001234;
        p0_req[0] = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        rst_n = 1'b0;
        p0_req[0] = 1'b0;
        #1;
        check("arst_strobes", {28'd0, wr_en[0], rd_en[0], p0_ack[0], p1_ack[0]}, 32'd0);
        check("arst_addr", 32'(rd_addr[0]), 32'd0);
        check("arst_rdata", {p0_rdata[0], p1_rdata[0]}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        p0_we[0] = 1'b1; p0_addr[0] = 25'h77; p0_wdata[0] = 16'h1357;
        p0_req[0] = 1'b1;
        wait_ack(0, 0, lat);
        p0_req[0] = 1'b0;
        check("post_rst_wr", lat, 32'd8);
        tick(); tick();
        p0_we[0] = 1'b0;
        p0_req[0] = 1'b1;
        wait_ack(0, 0, lat);
        check("post_rst_rd_lat", lat, 32'd9);
        check("post_rst_rd_data", 32'(p0_rdata[0]), 32'h00001357);
        p0_req[0] = 1'b0;
        tick(); tick();

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        base_ack1 = g_inst[1].n_ack1;
        p0_we[1] = 1'b1; p0_addr[1] = 25'h30; p0_wdata[1] = 16'h3333;
        p1_we[1] = 1'b1; p1_addr[1] = 25'h40; p1_wdata[1] = 16'h4444;
        both_held(1, 4'b0000, "fixed_order");
        check("fixed_starve", g_inst[1].n_ack1 - base_ack1, 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
